// File: rtl/csel_addsub_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with running accumulator.
// Stage 1 builds per-segment candidate sums, stage 2 resolves the select chain.

// One carry-select segment: both candidate sums (carry-in 0 and 1).
module csel_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] x,
    input  logic [SEG-1:0] y,
    output logic [SEG-1:0] sum0,
    output logic [SEG-1:0] sum1,
    output logic           co0,
    output logic           co1
);
    assign {co0, sum0} = {1'b0, x} + {1'b0, y};
    assign {co1, sum1} = {1'b0, x} + {1'b0, y} + (SEG+1)'(1);
endmodule

module csel_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             C_out,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);
    localparam int NSEG = WIDTH / SEG;

    typedef enum logic [1:0] {M_ADD = 2'b00, M_SUB = 2'b01, M_ACC = 2'b10, M_CLR = 2'b11} mode_e;

    mode_e in_mode;
    assign in_mode = mode_e'(mode);

    // Stage 1 state
    logic                       s1_valid;
    mode_e                      s1_mode;
    logic [SEG-1:0]             s1_sum_lo;
    logic                       s1_c_lo;
    logic [NSEG-1:1][SEG-1:0]   s1_sum0, s1_sum1;
    logic [NSEG-1:1]            s1_co0, s1_co1;
    logic                       s1_xm, s1_ym;

    // Pipeline control
    logic adv1, adv2, s1_acc_op, take;
    assign adv2      = !out_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    // acc is only written when an ACC/CLR leaves stage 1, so a following ACC must wait
    assign s1_acc_op = s1_valid && (s1_mode == M_ACC || s1_mode == M_CLR);
    assign in_ready  = adv1 && !(in_mode == M_ACC && s1_acc_op);
    assign take      = in_valid && in_ready;

    // Operand selection; CLR operands are don't-care, result is forced in stage 2
    logic [WIDTH-1:0] x, y;
    always_comb begin
        x = A;
        y = B;
        case (in_mode)
            M_SUB:   y = ~B;
            M_ACC: begin
                x = acc;
                y = A;
            end
            default: ;
        endcase
    end

    logic [NSEG-1:0][SEG-1:0] c_sum0, c_sum1;
    logic [NSEG-1:0]          c_co0, c_co1;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        csel_seg #(.SEG(SEG)) u_seg (
            .x    (x[k*SEG +: SEG]),
            .y    (y[k*SEG +: SEG]),
            .sum0 (c_sum0[k]),
            .sum1 (c_sum1[k]),
            .co0  (c_co0[k]),
            .co1  (c_co1[k])
        );
    end

    // Stage 1 register: segment 0 resolved with C_in, upper segments keep both candidates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= M_ADD;
            s1_sum_lo <= '0;
            s1_c_lo   <= 1'b0;
            s1_sum0   <= '0;
            s1_sum1   <= '0;
            s1_co0    <= '0;
            s1_co1    <= '0;
            s1_xm     <= 1'b0;
            s1_ym     <= 1'b0;
        end else if (adv1) begin
            s1_valid <= take;
            if (take) begin
                s1_mode   <= in_mode;
                s1_sum_lo <= C_in ? c_sum1[0] : c_sum0[0];
                s1_c_lo   <= C_in ? c_co1[0]  : c_co0[0];
                s1_sum0   <= c_sum0[NSEG-1:1];
                s1_sum1   <= c_sum1[NSEG-1:1];
                s1_co0    <= c_co0[NSEG-1:1];
                s1_co1    <= c_co1[NSEG-1:1];
                s1_xm     <= x[WIDTH-1];
                s1_ym     <= y[WIDTH-1];
            end
        end
    end

    // Stage 2 select chain: each segment picks its candidate by the previous resolved carry
    logic [NSEG-1:0][SEG-1:0] res_seg;
    logic [WIDTH-1:0]         res;
    logic                     carry, res_c, res_ov;
    always_comb begin
        carry      = s1_c_lo;
        res_seg    = '0;
        res_seg[0] = s1_sum_lo;
        for (int k = 1; k < NSEG; k++) begin
            res_seg[k] = carry ? s1_sum1[k] : s1_sum0[k];
            carry      = carry ? s1_co1[k]  : s1_co0[k];
        end
        res    = res_seg;
        res_c  = carry;
        res_ov = (s1_xm == s1_ym) && (res[WIDTH-1] != s1_xm);
        if (s1_mode == M_CLR) begin
            res    = '0;
            res_c  = 1'b0;
            res_ov = 1'b0;
        end
    end

    // Output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Out       <= '0;
            C_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Out   <= res;
                C_out <= res_c;
                ovf   <= res_ov;
            end
        end
    end

    // Accumulator written as ACC/CLR moves from stage 1 into stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s1_valid && adv2) begin
            if (s1_mode == M_ACC)      acc <= res;
            else if (s1_mode == M_CLR) acc <= '0;
        end
    end
endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Randomized + directed bench for csel_addsub_pipe against a behavioural model.
module tb_csel_addsub_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0, B = '0;
    logic         C_in = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Out;
    logic         C_out, ovf;
    logic [W-1:0] acc;

    csel_addsub_pipe #(.WIDTH(W), .SEG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C_in(C_in), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .Out(Out), .C_out(C_out), .ovf(ovf), .acc(acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         co;
        logic         ov;
        logic [W-1:0] acc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] macc = '0;
    int           checks = 0, errors = 0;
    logic         acc_now, out_now, rdy_seen, vld_seen;
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_val;
    logic [W-1:0] last_out;
    logic         last_co, last_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sequential semantics, acc as seen by ops in acceptance order
    task automatic model_accept();
        logic [W-1:0] x, y;
        logic [W:0]   s;
        exp_t         e;
        x = A;
        y = B;
        case (mode)
            2'b01: y = ~B;
            2'b10: begin x = macc; y = A; end
            default: ;
        endcase
        s    = {1'b0, x} + {1'b0, y} + (W+1)'(C_in);
        e.out = s[W-1:0];
        e.co  = s[W];
        e.ov  = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        if (mode == 2'b11) begin e.out = '0; e.co = 1'b0; e.ov = 1'b0; end
        if (mode == 2'b10) macc = e.out;
        else if (mode == 2'b11) macc = '0;
        e.acc = macc;
        exp_q.push_back(e);
    endtask

    // One clock: sample at negedge, score transfers, return 1 ns after the rising edge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        acc_now  = in_valid && in_ready;
        out_now  = out_valid && out_ready;
        rdy_seen = in_ready;
        vld_seen = out_valid;
        if (prev_stall) begin
            chk("hold_v", 32'(out_valid), 32'd1);
            chk("hold_o", 32'({Out, C_out, ovf}), 32'(prev_val));
        end
        prev_stall = out_valid && !out_ready;
        prev_val   = {Out, C_out, ovf};
        if (out_now) begin
            got_q.push_back(Out);
            last_out = Out; last_co = C_out; last_ov = ovf;
            if (exp_q.size() == 0) chk("spurious", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("out", 32'(Out), 32'(e.out));
                chk("cout", 32'(C_out), 32'(e.co));
                chk("ovf", 32'(ovf), 32'(e.ov));
                chk("acc", 32'(acc), 32'(e.acc));
            end
        end
        if (acc_now) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int n = 0;
        mode = m; A = a; B = b; C_in = c; in_valid = 1'b1;
        do begin cycle(); n++; end while (!acc_now && n < 50);
        if (!acc_now) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run1(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] eo, input logic ec, input logic ev);
        int n = 0;
        out_ready = 1'b1;
        send(m, a, b, c);
        do begin cycle(); n++; end while (!out_now && n < 20);
        chk("dir_wait", 32'(out_now), 32'd1);
        chk("dir_out", 32'(last_out), 32'(eo));
        chk("dir_cout", 32'(last_co), 32'(ec));
        chk("dir_ovf", 32'(last_ov), 32'(ev));
    endtask

    initial begin
        int k, n, acc_cnt, cyc, stall;
        logic [W-1:0] vals[3];

        // Reset state
        #2;
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd1);
        chk("rst_out", 32'(Out), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Select chain and subtract corners
        run1(2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run1(2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run1(2'b01, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run1(2'b01, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Accumulate with hazard: CLR then ACC 3,4,5 held valid every cycle
        got_q.delete();
        out_ready = 1'b1;
        mode = 2'b11; A = '0; B = '0; C_in = 1'b0; in_valid = 1'b1;
        cycle();
        vals = '{16'd3, 16'd4, 16'd5};
        k = 0; n = 0;
        mode = 2'b10;
        while (k < 3 && n < 12) begin
            A = vals[k];
            cycle();
            chk("haz_rdy", 32'(rdy_seen), 32'(n % 2));
            if (acc_now) k++;
            n++;
        end
        chk("haz_cycles", 32'(n), 32'd6);
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("haz_cnt", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("haz_o0", 32'(got_q[0]), 32'd0);
            chk("haz_o1", 32'(got_q[1]), 32'd3);
            chk("haz_o2", 32'(got_q[2]), 32'd7);
            chk("haz_o3", 32'(got_q[3]), 32'd12);
        end
        chk("haz_acc", 32'(acc), 32'd12);

        // Backpressure: 4 ADDs (i+1)+(i+1) with 5 stalled cycles
        got_q.delete();
        out_ready = 1'b0; mode = 2'b00; C_in = 1'b0; in_valid = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            A = W'(acc_cnt + 1); B = W'(acc_cnt + 1);
            cycle();
            if (acc_now) acc_cnt++;
        end
        chk("bp_accepts", 32'(acc_cnt), 32'd2);
        chk("bp_rdy", 32'(rdy_seen), 32'd0);
        chk("bp_held", 32'(Out), 32'd2);
        out_ready = 1'b1;
        n = 0;
        while (acc_cnt < 4 && n < 20) begin
            A = W'(acc_cnt + 1); B = W'(acc_cnt + 1);
            cycle();
            if (acc_now) acc_cnt++;
            n++;
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("bp_cnt", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4)
            for (int i = 0; i < 4; i++) chk("bp_out", 32'(got_q[i]), 32'(2 * (i + 1)));

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        send(2'b00, 16'd1, 16'd1, 1'b0);
        send(2'b00, 16'd2, 16'd2, 1'b0);
        chk("mid_full", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ovalid", 32'(out_valid), 32'd0);
        chk("mid_acc", 32'(acc), 32'd0);
        chk("mid_out", 32'(Out), 32'd0);
        chk("mid_rdy", 32'(in_ready), 32'd1);
        exp_q.delete(); macc = '0; prev_stall = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        got_q.delete();
        send(2'b00, 16'd5, 16'd6, 1'b0);
        cycle();
        chk("lat_e1", 32'(vld_seen), 32'd0);
        cycle();
        chk("lat_e2", 32'(vld_seen), 32'd1);
        chk("lat_val", 32'(got_q.size() > 0 ? got_q[0] : 16'hDEAD), 32'd11);

        // Random ops with stall bursts
        acc_cnt = 0; cyc = 0; stall = 0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            mode     = 2'($urandom_range(0, 3));
            A        = W'($urandom);
            B        = W'($urandom);
            C_in     = 1'($urandom);
            if (stall > 0) begin out_ready = 1'b0; stall--; end
            else if ($urandom_range(0, 9) == 0) begin out_ready = 1'b0; stall = $urandom_range(0, 4); end
            else out_ready = 1'b1;
            cycle();
            if (acc_now) acc_cnt++;
            cyc++;
        end
        chk("rnd_done", 32'(acc_cnt), 32'd10000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) cycle();
        chk("rnd_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
